// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side blocks: data width,
// arbiter FSM state encoding and default timing parameters.
package uart_pkg;

   localparam int DATA_SIZE         = 8;
   localparam int CNT_W             = 16;
   localparam int DEF_STOP_TICKS    = 1;
   localparam int DEF_TIMEOUT_TICKS = 15;

   // 3-bit arbiter state encoding.
   typedef enum logic [2:0] {
      ST_ARB       = 3'd0,
      ST_LAUNCH    = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_ACK       = 3'd4,
      ST_GAP       = 3'd5,
      ST_RECOVER   = 3'd6
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of producer-side and uart_tx-side signals around the arbiter.
// The arbiter uses the slave view; the environment (producers plus the
// uart_tx hookup) uses the master view.
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int N_REQ = 4
);
   localparam int GID_W = $clog2(N_REQ);

   logic [N_REQ-1:0]           req;
   logic [DATA_SIZE*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]           ack;
   logic [DATA_SIZE-1:0]       uart_data;
   logic                       uart_start;
   logic                       uart_done;
   logic                       uart_reset;
   logic                       busy;
   logic [GID_W-1:0]           grant_id;
   logic                       err_timeout;

   modport slave (
      input  req, req_data, uart_done,
      output ack, uart_data, uart_start, uart_reset, busy, grant_id, err_timeout
   );

   modport master (
      output req, req_data, uart_done,
      input  ack, uart_data, uart_start, uart_reset, busy, grant_id, err_timeout
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request bit scanning
// upward from the slot after i_last, wrapping modulo N. The slot i_last
// itself has the lowest priority, which is what gives fairness.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] i_req,
   input  logic [W-1:0] i_last,
   output logic [W-1:0] o_idx,
   output logic         o_valid
);

   logic [W-1:0] w_idx;
   logic [W-1:0] w_cand;

   // Walk from the farthest candidate to the nearest so the nearest set bit wins.
   always_comb begin
      w_idx  = i_last;
      w_cand = i_last;
      for (int k = N; k >= 1; k--) begin
         w_cand = W'((int'(i_last) + k) % N);
         w_idx  = i_req[w_cand] ? w_cand : w_idx;
      end
   end

   assign o_idx   = w_idx;
   assign o_valid = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among N_REQ byte producers.
// Latches the winner's byte, pulses uart_start, follows uart_tx's tx_done
// through accept (low) and completion (high), acknowledges the requester
// and enforces an idle gap. A watchdog resets a stuck transmitter and
// drops the byte, flagging a sticky error.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ         = 4,
   parameter int STOP_TICKS    = DEF_STOP_TICKS,
   parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
   input  logic               s_tick,
   input  logic               reset,
   uart_tx_arbiter_if.slave   bus
);

   localparam int GID_W = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_TICKS - 32'sd1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STOP_TICKS - 32'sd1);

   arb_state_t           r_state;
   logic [N_REQ-1:0]     r_ack;
   logic [DATA_SIZE-1:0] r_uart_data;
   logic                 r_uart_start;
   logic                 r_uart_reset;
   logic                 r_busy;
   logic [GID_W-1:0]     r_grant_id;
   logic                 r_err_timeout;
   logic [CNT_W-1:0]     r_wdog;
   logic [CNT_W-1:0]     r_gap;

   logic [GID_W-1:0]     w_win_id;
   logic                 w_win_valid;
   logic [DATA_SIZE-1:0] w_win_data;
   logic [N_REQ-1:0]     w_grant_onehot;
   logic                 w_wdog_last;
   logic                 w_gap_last;

   rr_pick #(
      .N (N_REQ),
      .W (GID_W)
   ) u_rr_pick (
      .i_req   (bus.req),
      .i_last  (r_grant_id),
      .o_idx   (w_win_id),
      .o_valid (w_win_valid)
   );

   assign w_win_data     = bus.req_data[DATA_SIZE*int'(w_win_id) +: DATA_SIZE];
   assign w_grant_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;
   assign w_wdog_last    = (r_wdog >= WDOG_LAST);
   assign w_gap_last     = (r_gap >= GAP_LAST);

   // Arbiter FSM: every output is a register updated on the transition into its state.
   always_ff @(posedge s_tick or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_ARB;
         r_ack         <= '0;
         r_uart_data   <= '0;
         r_uart_start  <= 1'b0;
         r_uart_reset  <= 1'b0;
         r_busy        <= 1'b0;
         r_grant_id    <= GID_W'(N_REQ - 32'sd1);
         r_err_timeout <= 1'b0;
         r_wdog        <= '0;
         r_gap         <= '0;
      end else begin
         case (r_state)
            ST_ARB: begin
               if (w_win_valid) begin
                  r_grant_id   <= w_win_id;
                  r_uart_data  <= w_win_data;
                  r_uart_start <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= ST_LAUNCH;
               end else begin
                  r_state      <= ST_ARB;
               end
            end

            ST_LAUNCH: begin
               r_uart_start <= 1'b0;
               r_wdog       <= '0;
               r_state      <= ST_WAIT_BUSY;
            end

            // tx_done falling is uart_tx's confirmation that it took the frame.
            ST_WAIT_BUSY: begin
               if (!bus.uart_done) begin
                  r_wdog  <= r_wdog + CNT_W'(1);
                  r_state <= ST_WAIT_DONE;
               end else if (w_wdog_last) begin
                  r_ack         <= w_grant_onehot;
                  r_uart_reset  <= 1'b1;
                  r_err_timeout <= 1'b1;
                  r_state       <= ST_RECOVER;
               end else begin
                  r_wdog  <= r_wdog + CNT_W'(1);
               end
            end

            // Normal completion takes priority over a watchdog expiring on the same tick.
            ST_WAIT_DONE: begin
               if (bus.uart_done) begin
                  r_ack   <= w_grant_onehot;
                  r_state <= ST_ACK;
               end else if (w_wdog_last) begin
                  r_ack         <= w_grant_onehot;
                  r_uart_reset  <= 1'b1;
                  r_err_timeout <= 1'b1;
                  r_state       <= ST_RECOVER;
               end else begin
                  r_wdog  <= r_wdog + CNT_W'(1);
               end
            end

            // ACK and RECOVER both last one tick and then enter the idle gap.
            ST_ACK, ST_RECOVER: begin
               r_ack        <= '0;
               r_uart_reset <= 1'b0;
               r_gap        <= '0;
               if (STOP_TICKS == 0) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_ARB;
               end else begin
                  r_state <= ST_GAP;
               end
            end

            ST_GAP: begin
               if (w_gap_last) begin
                  r_busy  <= 1'b0;
                  r_state <= ST_ARB;
               end else begin
                  r_gap   <= r_gap + CNT_W'(1);
               end
            end

            default: begin
               r_ack        <= '0;
               r_uart_start <= 1'b0;
               r_uart_reset <= 1'b0;
               r_busy       <= 1'b0;
               r_state      <= ST_ARB;
            end
         endcase
      end
   end

   assign bus.ack         = r_ack;
   assign bus.uart_data   = r_uart_data;
   assign bus.uart_start  = r_uart_start;
   assign bus.uart_reset  = r_uart_reset;
   assign bus.busy        = r_busy;
   assign bus.grant_id    = r_grant_id;
   assign bus.err_timeout = r_err_timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_tx transmitter among N_REQ byte producers. It latches the winning requester's byte, launches a frame, and holds the data stable for the whole frame. It tracks the frame through uart_tx's tx_done, acknowledges the requester, and enforces an idle/stop gap between frames. A watchdog recovers a stuck transmitter. It sits between the producer blocks and uart_tx, in the same s_tick domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
STOP_TICKS, 1, extra idle ticks (tx held high) inserted after each frame before the next launch
TIMEOUT_TICKS, 15, max ticks from launch to tx_done rising before recovery

Ports:
s_tick  input  1  block clock (baud tick domain shared with uart_tx)
reset  input  1  asynchronous, active-low reset
req  input  N_REQ  per-requester byte-pending; held until ack
req_data  input  8*N_REQ  byte for requester i at bits [8i+7:8i]
ack  output  N_REQ  one-tick pulse: requester's byte fully sent
uart_data  output  8  to uart_tx.data; stable from launch until ack
uart_start  output  1  to uart_tx.transmission; one-tick pulse
uart_done  input  1  from uart_tx.tx_done
uart_reset  output  1  to uart_tx.reset (active-high, synchronous); one-tick pulse on timeout
busy  output  1  high in any state other than ARB
grant_id  output  clog2(N_REQ)  index of current/last winner
err_timeout  output  1  sticky; set on watchdog expiry, cleared only by reset

Behaviour:
- Reset (reset=0, async): state=ARB, ack=0, uart_data=0, uart_start=0, uart_reset=0, busy=0, grant_id=N_REQ-1 (so requester 0 wins first), err_timeout=0, counters=0.
- All outputs are registered.
- ARB: if req!=0, pick the first set bit scanning from grant_id+1 upward, wrapping modulo N_REQ. Latch grant_id and uart_data=req_data[winner]. Set uart_start=1 and go to LAUNCH. If req==0, stay.
- LAUNCH (1 tick): uart_start drops to 0 on exit. Go to WAIT_BUSY and clear the watchdog.
- WAIT_BUSY: wait for uart_done==0, which confirms uart_tx accepted the frame. Then go to WAIT_DONE.
- WAIT_DONE: wait for uart_done==1. Then go to ACK.
- Watchdog: increments each tick in WAIT_BUSY and WAIT_DONE. When it reaches TIMEOUT_TICKS, go to RECOVER.
- ACK (1 tick): ack[grant_id]=1. Go to GAP with the gap counter cleared.
- GAP: hold STOP_TICKS ticks with uart_start=0, then go to ARB. If STOP_TICKS=0, go to ARB directly after ACK. The uart_tx IDLE tick during ACK always gives at least 1 high stop tick.
- RECOVER (1 tick): uart_reset=1, err_timeout=1, ack[grant_id]=1 (byte dropped), then go to GAP.
- Latency: req rising in ARB gives uart_start at the next edge. A nominal frame gives ack 11 ticks after uart_start (1 accept + 8 data + 1 done + 1 observe).
- uart_data is never modified outside the ARB->LAUNCH transition.
- If req[grant_id] is dropped mid-frame, it is ignored. The frame completes and ack still pulses.
- req and req_data for non-granted requesters are not sampled while busy.
- A requester re-asserting req immediately after ack loses to any other pending requester (round-robin fairness).
- Only one ack bit is ever high in a cycle. ack and uart_start are never high together.
- Reset mid-frame: immediate return to reset values. uart_tx has its own reset, so the system must reset both.

Decomposition:
- Shared package uart_pkg:
  - DATA_SIZE=8
  - state encoding (ARB, LAUNCH, WAIT_BUSY, WAIT_DONE, ACK, GAP, RECOVER) as a 3-bit localparam set
  - default STOP_TICKS and TIMEOUT_TICKS
- One sub-module, rr_pick: combinational round-robin priority picker. Inputs are req and the last grant. Outputs are the winner index and a valid flag. It can be reused by a future RX dispatcher.

Test Plan:
- Single request: req=4'b0001, req_data[7:0]=8'hA5, with uart_tx attached. Required: uart_start pulse 1 tick after req; tx serialises 0,1,0,1,0,0,1,0,1 (start + LSB-first); ack=4'b0001 exactly once; busy low after the GAP.
- Fairness: req=4'b1111 held, bytes 8'h11/8'h22/8'h33/8'h44. Required: grant order 0,1,2,3,0; ack pulses in that order.
- Back-to-back same requester: req[2] re-asserted the tick after its ack, with req[0] pending. Required: requester 0 is granted next, then 2.
- Stop gap: continuous req[1], STOP_TICKS=3. Required: tx high for ≥4 ticks between consecutive frames; uart_start never high while uart_done is low.
- Timeout: uart_done tied to 1. Required: after 15 ticks in WAIT_BUSY, uart_reset pulses, err_timeout=1 (sticky), ack for the granted requester, and the arbiter returns to ARB.
- Async reset mid-frame: reset=0 during WAIT_DONE. Required: ack=0, uart_start=0, busy=0, and err_timeout=0 immediately with no clock edge; the next grant goes to requester 0.
